// File: rtl/vga_timing_pkg.sv
// Timing constants for 640x480@60 plus the small helpers shared by the VGA
// sync path.
package vga_timing_pkg;

  localparam int CNT_W = 10;

  localparam int VGA_H_VISIBLE = 640;
  localparam int VGA_H_FP      = 16;
  localparam int VGA_H_SYNC    = 96;
  localparam int VGA_H_BP      = 48;
  localparam int VGA_V_VISIBLE = 480;
  localparam int VGA_V_FP      = 10;
  localparam int VGA_V_SYNC    = 2;
  localparam int VGA_V_BP      = 33;

  localparam int VGA_H_TOTAL = VGA_H_VISIBLE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int VGA_V_TOTAL = VGA_V_VISIBLE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  localparam logic VGA_SYNC_ACTIVE = 1'b0;

  typedef logic [CNT_W-1:0] cnt_t;

  function automatic logic in_window(input cnt_t v, input cnt_t lo, input cnt_t hi);
    return (v >= lo) && (v < hi);
  endfunction

  // Maps "pulse active" onto the connector level for the given polarity.
  function automatic logic sync_level(input logic active, input logic polarity);
    return active ? polarity : ~polarity;
  endfunction

endpackage

// File: rtl/vga_sync_gen_if.sv
// Timing bus from the VGA sync generator to the pixel colour stage and the
// connector drivers.
interface vga_sync_gen_if;
  import vga_timing_pkg::*;

  logic pixel_tick;
  cnt_t pixel_x;
  cnt_t pixel_y;
  logic vga_valid;
  logic hsync;
  logic vsync;
  logic line_start;
  logic frame_start;

  modport master (
    output pixel_tick, pixel_x, pixel_y, vga_valid,
    output hsync, vsync, line_start, frame_start
  );

  modport slave (
    input pixel_tick, pixel_x, pixel_y, vga_valid,
    input hsync, vsync, line_start, frame_start
  );

endinterface

// File: rtl/pixel_tick_gen.sv
// Divides clk_crystal by CLK_DIV into a one-cycle pixel enable; with
// CLK_DIV=1 the enable is permanently high.
module pixel_tick_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk_crystal,
  input  logic reset,
  output logic o_tick
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] r_div;

  always_ff @(posedge clk_crystal) begin
    if (reset) begin
      r_div <= '0;
    end else if (r_div == DIV_LAST) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + DIV_W'(1);
    end
  end

  assign o_tick = (r_div == DIV_LAST);

endmodule

// File: rtl/vga_sync_gen.sv
// VGA timing generator: pixel divider, h/v counters and sync decode.
// Define VGA_SYNC_ALIGN_EN to delay hsync/vsync/vga_valid by one pixel period.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int   CLK_DIV     = 4,
  parameter int   H_VISIBLE   = VGA_H_VISIBLE,
  parameter int   H_FP        = VGA_H_FP,
  parameter int   H_SYNC      = VGA_H_SYNC,
  parameter int   H_BP        = VGA_H_BP,
  parameter int   V_VISIBLE   = VGA_V_VISIBLE,
  parameter int   V_FP        = VGA_V_FP,
  parameter int   V_SYNC      = VGA_V_SYNC,
  parameter int   V_BP        = VGA_V_BP,
  parameter logic SYNC_ACTIVE = VGA_SYNC_ACTIVE
) (
  input  logic           clk_crystal,
  input  logic           reset,
  vga_sync_gen_if.master vga
);

  localparam cnt_t H_LAST    = cnt_t'(H_VISIBLE + H_FP + H_SYNC + H_BP - 1);
  localparam cnt_t V_LAST    = cnt_t'(V_VISIBLE + V_FP + V_SYNC + V_BP - 1);
  localparam cnt_t H_VIS_END = cnt_t'(H_VISIBLE);
  localparam cnt_t V_VIS_END = cnt_t'(V_VISIBLE);
  localparam cnt_t H_SYNC_LO = cnt_t'(H_VISIBLE + H_FP);
  localparam cnt_t H_SYNC_HI = cnt_t'(H_VISIBLE + H_FP + H_SYNC);
  localparam cnt_t V_SYNC_LO = cnt_t'(V_VISIBLE + V_FP);
  localparam cnt_t V_SYNC_HI = cnt_t'(V_VISIBLE + V_FP + V_SYNC);

  logic w_tick;
  cnt_t w_x_nxt;
  cnt_t w_y_nxt;
  logic w_valid_nxt;
  logic w_hsync_nxt;
  logic w_vsync_nxt;
  logic w_line_nxt;
  logic w_frame_nxt;

  cnt_t r_x;
  cnt_t r_y;
  logic r_valid;
  logic r_hsync;
  logic r_vsync;
  logic r_line;
  logic r_frame;

  pixel_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk_crystal (clk_crystal),
    .reset       (reset),
    .o_tick      (w_tick)
  );

  // Decode from the next-state position so the sync outputs line up with the counters.
  always_comb begin
    w_x_nxt     = r_x;
    w_y_nxt     = r_y;
    w_line_nxt  = 1'b0;
    w_frame_nxt = 1'b0;
    if (w_tick) begin
      if (r_x == H_LAST) begin
        w_x_nxt    = '0;
        w_line_nxt = 1'b1;
        if (r_y == V_LAST) begin
          w_y_nxt     = '0;
          w_frame_nxt = 1'b1;
        end else begin
          w_y_nxt = r_y + cnt_t'(1);
        end
      end else begin
        w_x_nxt = r_x + cnt_t'(1);
      end
    end
    w_valid_nxt = (w_x_nxt < H_VIS_END) && (w_y_nxt < V_VIS_END);
    w_hsync_nxt = sync_level(in_window(w_x_nxt, H_SYNC_LO, H_SYNC_HI), SYNC_ACTIVE);
    w_vsync_nxt = sync_level(in_window(w_y_nxt, V_SYNC_LO, V_SYNC_HI), SYNC_ACTIVE);
  end

  always_ff @(posedge clk_crystal) begin
    if (reset) begin
      r_x     <= H_LAST;
      r_y     <= V_LAST;
      r_valid <= 1'b0;
      r_hsync <= ~SYNC_ACTIVE;
      r_vsync <= ~SYNC_ACTIVE;
      r_line  <= 1'b0;
      r_frame <= 1'b0;
    end else begin
      r_x     <= w_x_nxt;
      r_y     <= w_y_nxt;
      r_valid <= w_valid_nxt;
      r_hsync <= w_hsync_nxt;
      r_vsync <= w_vsync_nxt;
      r_line  <= w_line_nxt;
      r_frame <= w_frame_nxt;
    end
  end

`ifdef VGA_SYNC_ALIGN_EN
  logic r_valid_d;
  logic r_hsync_d;
  logic r_vsync_d;

  // One pixel of delay for colour pipelines that are a full pixel behind.
  always_ff @(posedge clk_crystal) begin
    if (reset) begin
      r_valid_d <= 1'b0;
      r_hsync_d <= ~SYNC_ACTIVE;
      r_vsync_d <= ~SYNC_ACTIVE;
    end else if (w_tick) begin
      r_valid_d <= r_valid;
      r_hsync_d <= r_hsync;
      r_vsync_d <= r_vsync;
    end
  end

  assign vga.vga_valid = r_valid_d;
  assign vga.hsync     = r_hsync_d;
  assign vga.vsync     = r_vsync_d;
`else
  assign vga.vga_valid = r_valid;
  assign vga.hsync     = r_hsync;
  assign vga.vsync     = r_vsync;
`endif

  assign vga.pixel_tick  = w_tick;
  assign vga.pixel_x     = r_x;
  assign vga.pixel_y     = r_y;
  assign vga.line_start  = r_line;
  assign vga.frame_start = r_frame;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: a full-size 640x480 instance at CLK_DIV=4 and a
// shrunken-timing instance at CLK_DIV=1 so whole frames fit in a short run.
`timescale 1ns/1ps
module tb_vga_sync_gen;

`ifdef VGA_SYNC_ALIGN_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  // flags f = {vga_valid, hsync, vsync, line_start, frame_start}; t<0 skips entry-latency check
  typedef struct { int x; int y; logic [4:0] f; int t; } pt_t;
  typedef struct { int period; int ticks; int hs_low; int hs_first; int hs_last; int valid; int ls_hi; } ln_t;
  typedef struct { int period; int vs_low; int valid; int valid_bad; int fs_hi; } fr_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a;
  logic rst_b;

  vga_sync_gen_if if_a();
  vga_sync_gen_if if_b();

  vga_sync_gen #(.CLK_DIV(4)) u_dut_a (
    .clk_crystal (clk),
    .reset       (rst_a),
    .vga         (if_a)
  );

  vga_sync_gen #(
    .CLK_DIV(1), .H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_VISIBLE(6), .V_FP(1), .V_SYNC(2), .V_BP(2)
  ) u_dut_b (
    .clk_crystal (clk),
    .reset       (rst_b),
    .vga         (if_b)
  );

  int n_cmp = 0;
  int n_bad = 0;

  pt_t pt_q[2][$];
  ln_t ln_q[2][$];
  fr_t fr_q[2][$];
  bit  done_a = 1'b0;
  bit  done_b = 1'b0;

  logic [9:0] prev_x[2];
  logic [9:0] prev_y[2];
  logic       prev_ls[2];
  logic       prev_fs[2];
  bit         have_ln[2];
  bit         have_fr[2];
  int         rel[2];
  ln_t        acc_l[2];
  fr_t        acc_f[2];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp = n_cmp + 1;
    if (act != exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic mon_step(input int k, input logic rst, input logic [9:0] x, input logic [9:0] y,
                          input logic tick, input logic valid, input logic hs, input logic vs,
                          input logic ls, input logic fs, input int vvis);
    pt_t   p;
    ln_t   l;
    fr_t   fr;
    string id;
    id = (k == 0) ? "a" : "b";
    if (rst) begin
      have_ln[k] = 1'b0;
      have_fr[k] = 1'b0;
      rel[k]     = 0;
    end else begin
      rel[k] = rel[k] + 1;
    end
    if (pt_q[k].size() > 0 && (x !== prev_x[k] || y !== prev_y[k]) &&
        int'(x) == pt_q[k][0].x && int'(y) == pt_q[k][0].y) begin
      p = pt_q[k].pop_front();
      chk($sformatf("%s_flags@(%0d,%0d)", id, p.x, p.y), int'({valid, hs, vs, ls, fs}), int'(p.f));
      if (p.t >= 0) chk($sformatf("%s_entry_cycles", id), rel[k], p.t);
    end
    if (!rst && ls && !prev_ls[k]) begin
      if (have_ln[k] && ln_q[k].size() > 0) begin
        l = ln_q[k].pop_front();
        chk({id, "_line_period"}, acc_l[k].period, l.period);
        chk({id, "_line_ticks"}, acc_l[k].ticks, l.ticks);
        chk({id, "_hsync_low_clk"}, acc_l[k].hs_low, l.hs_low);
        chk({id, "_hsync_first_x"}, acc_l[k].hs_first, l.hs_first);
        chk({id, "_hsync_last_x"}, acc_l[k].hs_last, l.hs_last);
        chk({id, "_line_valid_clk"}, acc_l[k].valid, l.valid);
        chk({id, "_line_start_width"}, acc_l[k].ls_hi, l.ls_hi);
      end
      acc_l[k]   = '{0, 0, 0, -1, -1, 0, 0};
      have_ln[k] = 1'b1;
    end
    if (!rst && fs && !prev_fs[k]) begin
      if (have_fr[k] && fr_q[k].size() > 0) begin
        fr = fr_q[k].pop_front();
        chk({id, "_frame_period"}, acc_f[k].period, fr.period);
        chk({id, "_vsync_low_clk"}, acc_f[k].vs_low, fr.vs_low);
        chk({id, "_frame_valid_clk"}, acc_f[k].valid, fr.valid);
        chk({id, "_valid_below_visible"}, acc_f[k].valid_bad, fr.valid_bad);
        chk({id, "_frame_start_width"}, acc_f[k].fs_hi, fr.fs_hi);
      end
      acc_f[k]   = '{0, 0, 0, 0, 0};
      have_fr[k] = 1'b1;
    end
    if (!rst) begin
      acc_l[k].period = acc_l[k].period + 1;
      acc_l[k].ticks  = acc_l[k].ticks + int'(tick);
      if (hs == 1'b0) begin
        acc_l[k].hs_low = acc_l[k].hs_low + 1;
        if (acc_l[k].hs_first < 0) acc_l[k].hs_first = int'(x);
        acc_l[k].hs_last = int'(x);
      end
      acc_l[k].valid  = acc_l[k].valid + int'(valid);
      acc_l[k].ls_hi  = acc_l[k].ls_hi + int'(ls);
      acc_f[k].period = acc_f[k].period + 1;
      if (vs == 1'b0) acc_f[k].vs_low = acc_f[k].vs_low + 1;
      acc_f[k].valid = acc_f[k].valid + int'(valid);
      if (valid && int'(y) >= vvis) acc_f[k].valid_bad = acc_f[k].valid_bad + 1;
      acc_f[k].fs_hi = acc_f[k].fs_hi + int'(fs);
    end
    prev_x[k]  = x;
    prev_y[k]  = y;
    prev_ls[k] = ls;
    prev_fs[k] = fs;
  endtask

  // Stimulus for the full-size instance: reset, first entry, two full lines.
  initial begin
    rst_a = 1'b1;
    pt_q[0].push_back('{799, 524, 5'b01100, -1});
    repeat (3) @(posedge clk);
    #1;
    pt_q[0].push_back('{0, 0, ALIGN ? 5'b01111 : 5'b11111, 5});
    pt_q[0].push_back('{1, 0, 5'b11100, -1});
    pt_q[0].push_back('{656, 0, ALIGN ? 5'b01100 : 5'b00100, -1});
    pt_q[0].push_back('{0, 1, ALIGN ? 5'b01110 : 5'b11110, -1});
    for (int i = 0; i < 2; i++)
      ln_q[0].push_back('{3200, 800, 384, ALIGN ? 657 : 656, ALIGN ? 752 : 751, 2560, 1});
    rst_a = 1'b0;
    for (int i = 0; i < 8000 && (pt_q[0].size() + ln_q[0].size()) > 0; i++) @(posedge clk);
    done_a = 1'b1;
  end

  // Stimulus for the small instance: lines, a frame, then a mid-frame reset at (5,3).
  initial begin
    rst_b = 1'b1;
    pt_q[1].push_back('{15, 10, 5'b01100, -1});
    repeat (3) @(posedge clk);
    #1;
    pt_q[1].push_back('{0, 0, ALIGN ? 5'b01111 : 5'b11111, 2});
    for (int i = 0; i < 2; i++)
      ln_q[1].push_back('{16, 16, 3, ALIGN ? 11 : 10, ALIGN ? 13 : 12, 8, 1});
    fr_q[1].push_back('{176, 32, 48, 0, 1});
    rst_b = 1'b0;
    for (int i = 0; i < 1000 && (pt_q[1].size() + ln_q[1].size() + fr_q[1].size()) > 0; i++)
      @(posedge clk);
    #1;
    for (int i = 0; i < 400 && !(if_b.pixel_x == 10'd5 && if_b.pixel_y == 10'd3); i++) begin
      @(posedge clk);
      #1;
    end
    rst_b = 1'b1;
    pt_q[1].push_back('{15, 10, 5'b01100, -1});
    repeat (3) @(posedge clk);
    #1;
    pt_q[1].push_back('{0, 0, ALIGN ? 5'b01111 : 5'b11111, 2});
    fr_q[1].push_back('{176, 32, 48, 0, 1});
    rst_b = 1'b0;
    for (int i = 0; i < 1000 && (pt_q[1].size() + fr_q[1].size()) > 0; i++) @(posedge clk);
    done_b = 1'b1;
  end

  // Monitor: samples both instances on the falling edge and scores against the queues.
  initial begin
    int guard;
    guard = 0;
    while (!(done_a && done_b) && guard < 30000) begin
      @(negedge clk);
      mon_step(0, rst_a, if_a.pixel_x, if_a.pixel_y, if_a.pixel_tick, if_a.vga_valid,
               if_a.hsync, if_a.vsync, if_a.line_start, if_a.frame_start, 480);
      mon_step(1, rst_b, if_b.pixel_x, if_b.pixel_y, if_b.pixel_tick, if_b.vga_valid,
               if_b.hsync, if_b.vsync, if_b.line_start, if_b.frame_start, 6);
      guard = guard + 1;
    end
    chk("run_within_budget", int'(guard >= 30000), 0);
    chk("a_pending_expectations", pt_q[0].size() + ln_q[0].size() + fr_q[0].size(), 0);
    chk("b_pending_expectations", pt_q[1].size() + ln_q[1].size() + fr_q[1].size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
